fetch_redirect_ctrl: RTL and testbench

Sequencing controller for the fetch stage and its branch predictor. It tracks every fetched instruction's prediction in an in-flight queue and checks each one against the execute-stage outcome. On a mispredict it generates the fetch-stage redirect controls (pc_redirect/branchAddress or flush_fetch/resolved_pc) and the BPU update signals (branch_resolved, branch_taken, ghr_history), then squashes wrong-path instructions for a fixed number of cycles. It sits between the execute stage and the fetch stage.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_redirect_ctrl_pred_queue.sv | 58 +++++
 rtl/fetch_redirect_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch redirect controller: FSM states, queue entry layout, PC step.
// Entries carry the GHR zero-extended to GHR_MAX_W so the layout is fixed across configurations.
// The top-level GHR_W parameter must not exceed GHR_MAX_W.
package fetch_ctrl_pkg;

  localparam int INST_BYTES = 4;
  localparam int GHR_MAX_W  = 16;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } state_e;

  typedef struct packed {
    logic [31:0]          pc;
    logic [31:0]          pred_pc;
    logic [GHR_MAX_W-1:0] ghr;
  } entry_t;

endpackage

// File: rtl/fetch_redirect_ctrl_pred_queue.sv
// Synchronous FIFO of in-flight predictions: push/pop/clear, head visible combinationally.
// Latency: a pushed entry becomes head one cycle later; clear wins over push and pop.
// Backpressure: push is dropped when full unless a pop frees a slot in the same cycle.
module pred_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         clear_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify requests against occupancy; a pop frees the slot a same-cycle push uses.
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
  end

  // Entry storage; contents beyond the pointers are don't-care so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: checks each retired instruction against its queued prediction and
// issues redirect/flush, BPU update and squash; all outputs except fetch_stall are registered.
// Optional FETCH_PERF_CNT_EN adds saturating branch and mispredict counters.
module fetch_redirect_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH         = 4,
  parameter int SQUASH_CYCLES = 2,
  parameter int GHR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [31:0]      f_pc,
  input  logic [31:0]      f_pred_pc,
  input  logic [GHR_W-1:0] f_ghr,
  input  logic             ex_valid,
  input  logic [31:0]      ex_pc,
  input  logic             ex_is_branch,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             fetch_stall,
  output logic             squash,
  output logic             pc_redirect,
  output logic [31:0]      branch_address,
  output logic             flush_fetch,
  output logic [31:0]      resolved_pc,
  output logic             branch_resolved,
  output logic             branch_taken,
  output logic [GHR_W-1:0] ghr_history,
  output logic             seq_err
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispredicts
`endif
);

  localparam int CW = $clog2(SQUASH_CYCLES) + 1;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  entry_t          push_ent;
  entry_t          head;
  logic            q_full, q_empty;
  logic            in_run, pop, push, br_taken, mispredict;
  logic [31:0]     actual_next;
  logic            ghr_unused;

  logic             pc_redirect_d, flush_fetch_d, branch_resolved_d, branch_taken_d, seq_err_d;
  logic [31:0]      branch_address_d, resolved_pc_d;
  logic [GHR_W-1:0] ghr_history_d;

  assign push_ent    = '{pc: f_pc, pred_pc: f_pred_pc, ghr: GHR_MAX_W'(f_ghr)};
  assign fetch_stall = q_full;
  assign squash      = (state_q == SQUASH);
  assign ghr_unused  = ^head.ghr;

  pred_queue #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (mispredict),
    .din_i   (push_ent),
    .head_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Resolve the head prediction against the executed outcome; wrong-path pushes are dropped.
  always_comb begin
    in_run      = (state_q == RUN);
    pop         = in_run && ex_valid && !q_empty;
    br_taken    = ex_is_branch && ex_taken;
    actual_next = br_taken ? ex_target : ex_pc + 32'(INST_BYTES);
    mispredict  = pop && (head.pred_pc != actual_next);
    push        = in_run && f_valid && (!q_full || pop) && !mispredict;
  end

  // Next-state for the squash window: hold SQUASH for SQUASH_CYCLES cycles after a mispredict.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = SQUASH;
          cnt_d   = CW'(SQUASH_CYCLES - 1);
        end
      end
      SQUASH: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

  // FSM state and squash counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next values of the registered outputs; data fields read zero when their strobe is idle.
  always_comb begin
    pc_redirect_d     = 1'b0;
    branch_address_d  = '0;
    flush_fetch_d     = 1'b0;
    resolved_pc_d     = '0;
    branch_resolved_d = 1'b0;
    branch_taken_d    = 1'b0;
    ghr_history_d     = '0;
    seq_err_d         = seq_err;
    if (pop && ex_is_branch) begin
      branch_resolved_d = 1'b1;
      branch_taken_d    = ex_taken;
      ghr_history_d     = head.ghr[GHR_W-1:0];
      resolved_pc_d     = ex_pc;
    end
    if (mispredict) begin
      if (br_taken) begin
        pc_redirect_d    = 1'b1;
        branch_address_d = ex_target;
      end else begin
        flush_fetch_d = 1'b1;
        resolved_pc_d = ex_pc;
      end
    end
    if ((pop && (ex_pc != head.pc)) || (in_run && ex_valid && q_empty)) begin
      seq_err_d = 1'b1;
    end
  end

  // Output registers, one cycle behind the execute-stage handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_redirect     <= 1'b0;
      branch_address  <= '0;
      flush_fetch     <= 1'b0;
      resolved_pc     <= '0;
      branch_resolved <= 1'b0;
      branch_taken    <= 1'b0;
      ghr_history     <= '0;
      seq_err         <= 1'b0;
    end else begin
      pc_redirect     <= pc_redirect_d;
      branch_address  <= branch_address_d;
      flush_fetch     <= flush_fetch_d;
      resolved_pc     <= resolved_pc_d;
      branch_resolved <= branch_resolved_d;
      branch_taken    <= branch_taken_d;
      ghr_history     <= ghr_history_d;
      seq_err         <= seq_err_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters fed from the registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (branch_resolved && (perf_branches != 32'hFFFF_FFFF)) begin
        perf_branches <= perf_branches + 32'd1;
      end
      if ((pc_redirect || flush_fetch) && (perf_mispredicts != 32'hFFFF_FFFF)) begin
        perf_mispredicts <= perf_mispredicts + 32'd1;
      end
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed scenarios plus randomized traffic against a queue model.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_fetch_redirect_ctrl;

  localparam int DEPTH = 4;
  localparam int SQ    = 2;
  localparam int GW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_valid, ex_valid, ex_is_branch, ex_taken;
  logic [31:0]   f_pc, f_pred_pc, ex_pc, ex_target;
  logic [GW-1:0] f_ghr;
  logic          fetch_stall, squash, pc_redirect, flush_fetch, branch_resolved, branch_taken, seq_err;
  logic [31:0]   branch_address, resolved_pc;
  logic [GW-1:0] ghr_history;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_branches, perf_mispredicts;
`endif

  always #5 clk = ~clk;

  fetch_redirect_ctrl #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQ), .GHR_W(GW)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_pc(f_pc), .f_pred_pc(f_pred_pc), .f_ghr(f_ghr),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
    .ex_target(ex_target),
    .fetch_stall(fetch_stall), .squash(squash), .pc_redirect(pc_redirect),
    .branch_address(branch_address), .flush_fetch(flush_fetch), .resolved_pc(resolved_pc),
    .branch_resolved(branch_resolved), .branch_taken(branch_taken), .ghr_history(ghr_history),
    .seq_err(seq_err)
`ifdef FETCH_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
`endif
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: list of outstanding predictions, remaining squash cycles, sticky error.
  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   pred;
    logic [GW-1:0] ghr;
  } ment_t;

  ment_t         mq[$];
  int            m_sq_left;
  logic          m_seq_err;
  logic          e_redirect, e_flush, e_bres, e_btaken;
  logic [31:0]   e_baddr, e_rpc;
  logic [GW-1:0] e_ghr;

  task automatic clear_model();
    mq.delete();
    m_sq_left = 0;
    m_seq_err = 1'b0;
    e_redirect = 1'b0; e_flush = 1'b0; e_bres = 1'b0; e_btaken = 1'b0;
    e_baddr = '0; e_rpc = '0; e_ghr = '0;
  endtask

  // Apply one cycle of inputs, advance the model by the same cycle, then step the clock.
  task automatic drive(input logic fv, input logic [31:0] fpc, input logic [31:0] fpred,
                       input logic [GW-1:0] fg, input logic ev, input logic [31:0] epc,
                       input logic eb, input logic et, input logic [31:0] etgt);
    bit          insq, pop, mis, push_ok;
    ment_t       h;
    logic [31:0] act;
    f_valid = fv; f_pc = fpc; f_pred_pc = fpred; f_ghr = fg;
    ex_valid = ev; ex_pc = epc; ex_is_branch = eb; ex_taken = et; ex_target = etgt;
    insq = (m_sq_left > 0);
    pop  = ev && !insq && (mq.size() > 0);
    mis  = 1'b0;
    e_redirect = 1'b0; e_flush = 1'b0; e_bres = 1'b0; e_btaken = 1'b0;
    e_baddr = '0; e_rpc = '0; e_ghr = '0;
    if (ev && !insq && mq.size() == 0) m_seq_err = 1'b1;
    if (pop) begin
      h = mq[0];
      if (epc != h.pc) m_seq_err = 1'b1;
      act = (eb && et) ? etgt : epc + 32'd4;
      mis = (h.pred != act);
      if (eb) begin
        e_bres = 1'b1; e_btaken = et; e_ghr = h.ghr; e_rpc = epc;
      end
      if (mis && eb && et) begin
        e_redirect = 1'b1; e_baddr = etgt;
      end else if (mis) begin
        e_flush = 1'b1; e_rpc = epc;
      end
    end
    push_ok = fv && !insq && ((mq.size() < DEPTH) || pop);
    if (insq)     m_sq_left--;
    else if (mis) m_sq_left = SQ;
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push_ok) mq.push_back('{fpc, fpred, fg});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    f_valid = 1'b0; f_pc = '0; f_pred_pc = '0; f_ghr = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if ({fetch_stall, squash, pc_redirect, branch_address, flush_fetch, resolved_pc,
         branch_resolved, branch_taken, ghr_history, seq_err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got stall=%b squash=%b redir=%b baddr=%h flush=%b rpc=%h bres=%b btk=%b ghr=%h serr=%b, want all 0",
               fetch_stall, squash, pc_redirect, branch_address, flush_fetch, resolved_pc,
               branch_resolved, branch_taken, ghr_history, seq_err);
    end
  endtask

  task automatic test_correct_predict();
    do_reset();
    drive(1'b1, 32'h10, 32'h14, 4'h0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 32'h10, 1'b0, 1'b0, '0);
    n_vec++;
    if ({pc_redirect, flush_fetch, squash, branch_resolved, seq_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL correct_quiet: got redir/flush/squash/bres/serr=%b want 00000",
               {pc_redirect, flush_fetch, squash, branch_resolved, seq_err});
    end
    drive(1'b0, '0, '0, '0, 1'b1, 32'h10, 1'b0, 1'b0, '0);
    n_vec++;
    if (seq_err !== 1'b1) begin
      n_bad++; $display("FAIL correct_queue_empty: seq_err got %b want 1", seq_err);
    end
  endtask

  task automatic test_taken_mispredict();
    do_reset();
    drive(1'b1, 32'h20, 32'h24, 4'h5, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h80);
    n_vec++;
    if ({pc_redirect, flush_fetch, branch_resolved, branch_taken, squash} !== 5'b10111) begin
      n_bad++;
      $display("FAIL taken_strobes: got redir/flush/bres/btk/squash=%b want 10111",
               {pc_redirect, flush_fetch, branch_resolved, branch_taken, squash});
    end
    n_vec++;
    if (branch_address !== 32'h80) begin
      n_bad++; $display("FAIL taken_addr: got %h want 00000080", branch_address);
    end
    n_vec++;
    if (ghr_history !== 4'h5) begin
      n_bad++; $display("FAIL taken_ghr: got %h want 5", ghr_history);
    end
    idle();
    n_vec++;
    if ({squash, pc_redirect} !== 2'b10) begin
      n_bad++; $display("FAIL taken_squash2: got squash/redir=%b want 10", {squash, pc_redirect});
    end
    idle();
    n_vec++;
    if (squash !== 1'b0) begin
      n_bad++; $display("FAIL taken_squash_end: got %b want 0", squash);
    end
  endtask

  task automatic test_not_taken_mispredict();
    do_reset();
    drive(1'b1, 32'h40, 32'h100, 4'h3, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100);
    n_vec++;
    if ({flush_fetch, pc_redirect, branch_resolved, branch_taken} !== 4'b1010) begin
      n_bad++;
      $display("FAIL nt_strobes: got flush/redir/bres/btk=%b want 1010",
               {flush_fetch, pc_redirect, branch_resolved, branch_taken});
    end
    n_vec++;
    if (resolved_pc !== 32'h40) begin
      n_bad++; $display("FAIL nt_resolved_pc: got %h want 00000040", resolved_pc);
    end
  endtask

  task automatic test_full_queue();
    logic [31:0] pcs[4];
    pcs[0] = 32'h104; pcs[1] = 32'h108; pcs[2] = 32'h10c; pcs[3] = 32'h200;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      n_vec++;
      if (fetch_stall !== 1'b0) begin
        n_bad++; $display("FAIL full_early_stall[%0d]: got %b want 0", i, fetch_stall);
      end
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h104 + 32'(4 * i), GW'(i), 1'b0, '0, 1'b0, 1'b0, '0);
    end
    n_vec++;
    if (fetch_stall !== 1'b1) begin
      n_bad++; $display("FAIL full_stall: got %b want 1", fetch_stall);
    end
    drive(1'b1, 32'h50, 32'h54, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h200, 32'h204, '0, 1'b1, 32'h100, 1'b0, 1'b0, '0);
    n_vec++;
    if ({fetch_stall, seq_err, flush_fetch} !== 3'b100) begin
      n_bad++;
      $display("FAIL full_push_pop: got stall/serr/flush=%b want 100", {fetch_stall, seq_err, flush_fetch});
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, '0, 1'b1, pcs[i], 1'b0, 1'b0, '0);
      n_vec++;
      if ({fetch_stall, seq_err, flush_fetch} !== 3'b000) begin
        n_bad++;
        $display("FAIL full_drain[%0d]: got stall/serr/flush=%b want 000", i, {fetch_stall, seq_err, flush_fetch});
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1, 32'h300, 1'b0, 1'b0, '0);
    n_vec++;
    if (seq_err !== 1'b1) begin
      n_bad++; $display("FAIL empty_pop_seq_err: got %b want 1", seq_err);
    end
  endtask

  task automatic test_mispredict_push();
    do_reset();
    drive(1'b1, 32'h300, 32'h304, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h304, 32'h308, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b1, 32'h308, 32'h30c, '0, 1'b1, 32'h300, 1'b1, 1'b1, 32'h400);
    n_vec++;
    if ({pc_redirect, squash} !== 2'b11) begin
      n_bad++; $display("FAIL mp_push_redirect: got redir/squash=%b want 11", {pc_redirect, squash});
    end
    for (int i = 0; i < SQ; i++) begin
      drive(1'b1, 32'h500, 32'h504, '0, 1'b1, 32'h304, 1'b0, 1'b0, '0);
      n_vec++;
      if ({seq_err, pc_redirect, flush_fetch, fetch_stall} !== 4'b0000) begin
        n_bad++;
        $display("FAIL mp_squash_ignore[%0d]: got serr/redir/flush/stall=%b want 0000", i,
                 {seq_err, pc_redirect, flush_fetch, fetch_stall});
      end
    end
    drive(1'b0, '0, '0, '0, 1'b1, 32'h308, 1'b0, 1'b0, '0);
    n_vec++;
    if (seq_err !== 1'b1) begin
      n_bad++; $display("FAIL mp_queue_cleared: seq_err got %b want 1", seq_err);
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    drive(1'b1, 32'h40, 32'h44, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 32'h44, 1'b0, 1'b0, '0);
    n_vec++;
    if (seq_err !== 1'b1) begin
      n_bad++; $display("FAIL seq_err_set: got %b want 1", seq_err);
    end
    for (int i = 0; i < 4; i++) idle();
    n_vec++;
    if (seq_err !== 1'b1) begin
      n_bad++; $display("FAIL seq_err_sticky: got %b want 1", seq_err);
    end
    do_reset();
    n_vec++;
    if (seq_err !== 1'b0) begin
      n_bad++; $display("FAIL seq_err_reset: got %b want 0", seq_err);
    end
  endtask

  task automatic test_reset_mid_squash();
    do_reset();
    drive(1'b1, 32'h20, 32'h24, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 32'h20, 1'b1, 1'b1, 32'h80);
    do_reset();
    n_vec++;
    if ({squash, pc_redirect, branch_resolved} !== 3'b000) begin
      n_bad++; $display("FAIL rst_mid_squash: got squash/redir/bres=%b want 000", {squash, pc_redirect, branch_resolved});
    end
    drive(1'b1, 32'h10, 32'h14, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    drive(1'b0, '0, '0, '0, 1'b1, 32'h10, 1'b0, 1'b0, '0);
    n_vec++;
    if ({seq_err, flush_fetch, squash} !== 3'b000) begin
      n_bad++; $display("FAIL rst_back_to_run: got serr/flush/squash=%b want 000", {seq_err, flush_fetch, squash});
    end
  endtask

  task automatic test_random();
    logic          fv, ev, eb, et;
    logic [31:0]   fpc, fpred, epc, etgt;
    logic [GW-1:0] fg;
    do_reset();
    for (int it = 0; it < 600; it++) begin
      if (it % 97 == 96) do_reset();
      else begin
        fv    = ($urandom_range(0, 3) != 0);
        fpc   = 32'($urandom_range(0, 255)) << 2;
        fpred = ($urandom_range(0, 3) != 0) ? fpc + 32'd4 : 32'($urandom_range(0, 255)) << 2;
        fg    = GW'($urandom);
        ev    = ($urandom_range(0, 1) != 0);
        eb    = ($urandom_range(0, 1) != 0);
        et    = ($urandom_range(0, 1) != 0);
        if (mq.size() > 0 && $urandom_range(0, 29) != 0) epc = mq[0].pc;
        else epc = 32'($urandom_range(0, 255)) << 2;
        if (mq.size() > 0 && $urandom_range(0, 2) != 0) etgt = mq[0].pred;
        else etgt = 32'($urandom_range(0, 255)) << 2;
        drive(fv, fpc, fpred, fg, ev, epc, eb, et, etgt);
      end
      n_vec++;
      if (fetch_stall !== (mq.size() == DEPTH)) begin
        n_bad++; $display("FAIL rnd_stall @%0d: got %b want %b", it, fetch_stall, mq.size() == DEPTH);
      end
      n_vec++;
      if (squash !== (m_sq_left > 0)) begin
        n_bad++; $display("FAIL rnd_squash @%0d: got %b want %b", it, squash, m_sq_left > 0);
      end
      n_vec++;
      if ({pc_redirect, flush_fetch, branch_resolved, branch_taken} !== {e_redirect, e_flush, e_bres, e_btaken}) begin
        n_bad++;
        $display("FAIL rnd_strobes @%0d: got redir/flush/bres/btk=%b want %b", it,
                 {pc_redirect, flush_fetch, branch_resolved, branch_taken}, {e_redirect, e_flush, e_bres, e_btaken});
      end
      n_vec++;
      if (branch_address !== e_baddr) begin
        n_bad++; $display("FAIL rnd_baddr @%0d: got %h want %h", it, branch_address, e_baddr);
      end
      n_vec++;
      if (resolved_pc !== e_rpc) begin
        n_bad++; $display("FAIL rnd_rpc @%0d: got %h want %h", it, resolved_pc, e_rpc);
      end
      n_vec++;
      if (ghr_history !== e_ghr) begin
        n_bad++; $display("FAIL rnd_ghr @%0d: got %h want %h", it, ghr_history, e_ghr);
      end
      n_vec++;
      if (seq_err !== m_seq_err) begin
        n_bad++; $display("FAIL rnd_seq_err @%0d: got %b want %b", it, seq_err, m_seq_err);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    f_valid = 1'b0; f_pc = '0; f_pred_pc = '0; f_ghr = '0;
    ex_valid = 1'b0; ex_pc = '0; ex_is_branch = 1'b0; ex_taken = 1'b0; ex_target = '0;
    clear_model();
    test_reset();
    test_correct_predict();
    test_taken_mispredict();
    test_not_taken_mispredict();
    test_full_queue();
    test_mispredict_push();
    test_seq_err();
    test_reset_mid_squash();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
